// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = s - x mod 2^WIDTH, LSB first, one bit per clock, with unsigned borrow.
// Optional signed-overflow output sov_out when SUB_SIGNED_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             bw_out
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             sov_out
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] x_sh_q, x_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bw_q, bw_d;
  logic             a, b, dbit, br_next, last;
`ifdef SUB_SIGNED_OVF_EN
  logic             s_msb_q, s_msb_d;
  logic             x_msb_q, x_msb_d;
  logic             sov_q, sov_d;
`endif

  always_comb begin
    state_d = state_q;
    s_sh_d  = s_sh_q;
    x_sh_d  = x_sh_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bw_d    = bw_q;
`ifdef SUB_SIGNED_OVF_EN
    s_msb_d = s_msb_q;
    x_msb_d = x_msb_q;
    sov_d   = sov_q;
`endif
    a       = s_sh_q[0];
    b       = x_sh_q[0];
    dbit    = a ^ b ^ br_q;
    br_next = (~a & b) | (~(a ^ b) & br_q);
    last    = (cnt_q == CW'(WIDTH - 1));

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_sh_d  = s_in;
          x_sh_d  = x_in;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef SUB_SIGNED_OVF_EN
          s_msb_d = s_in[WIDTH-1];
          x_msb_d = x_in[WIDTH-1];
`endif
        end
      end
      RUN: begin
        res_d  = {dbit, res_q[WIDTH-1:1]};
        br_d   = br_next;
        s_sh_d = {1'b0, s_sh_q[WIDTH-1:1]};
        x_sh_d = {1'b0, x_sh_q[WIDTH-1:1]};
        if (last) begin
          // Outputs load only here so they stay frozen outside the DONE entry edge.
          d_d     = res_d;
          bw_d    = br_next;
          state_d = DONE;
`ifdef SUB_SIGNED_OVF_EN
          sov_d   = (s_msb_q ^ x_msb_q) & (s_msb_q ^ dbit);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_sh_q  <= '0;
      x_sh_q  <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bw_q    <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      s_msb_q <= 1'b0;
      x_msb_q <= 1'b0;
      sov_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_sh_q  <= s_sh_d;
      x_sh_q  <= x_sh_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bw_q    <= bw_d;
`ifdef SUB_SIGNED_OVF_EN
      s_msb_q <= s_msb_d;
      x_msb_q <= x_msb_d;
      sov_q   <= sov_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d_out     = d_q;
  assign bw_out    = bw_q;
`ifdef SUB_SIGNED_OVF_EN
  assign sov_out   = sov_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=6); signed-overflow vectors only with SUB_SIGNED_OVF_EN.
module tb_serial_subtractor;

  localparam int W = 6;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s_in;
  logic [W-1:0] x_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d_out;
  logic         bw_out;
`ifdef SUB_SIGNED_OVF_EN
  logic         sov_out;
`endif

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s_in     (s_in),
    .x_in     (x_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .d_out    (d_out),
    .bw_out   (bw_out)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .sov_out  (sov_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair, wait (bounded) for out_valid and check latency and result.
  // Leaves the bench #1 after the edge that entered DONE.
  task automatic do_op(input string tag, input logic [W-1:0] s, input logic [W-1:0] x,
                       input logic [W-1:0] exp_d, input logic exp_bw, input bit noisy);
    int unsigned n;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    s_in = s;
    x_in = x;
    in_valid = 1'b1;
    tick();
    if (noisy) begin
      s_in = 6'h01;
      x_in = 6'h3F;
    end else begin
      in_valid = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 20) begin
      if (n > 0) check({tag, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
      tick();
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, n, W);
    check({tag, "_d"}, {26'd0, d_out}, {26'd0, exp_d});
    check({tag, "_bw"}, {31'd0, bw_out}, {31'd0, exp_bw});
  endtask

  task automatic release_done(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_exit_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_exit_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    s_in      = '0;
    x_in      = '0;
    #23;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_d", {26'd0, d_out}, 32'd0);
    check("rst_bw", {31'd0, bw_out}, 32'd0);
`ifdef SUB_SIGNED_OVF_EN
    check("rst_sov", {31'd0, sov_out}, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    do_op("t1", 6'h2A, 6'h11, 6'h19, 1'b0, 1'b0);
    release_done("t1");

    do_op("t2a", 6'h05, 6'h09, 6'h3C, 1'b1, 1'b0);
    release_done("t2a");
    do_op("t2b", 6'h00, 6'h00, 6'h00, 1'b0, 1'b0);
    release_done("t2b");

    out_ready = 1'b0;
    do_op("t3", 6'h05, 6'h09, 6'h3C, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t3_hold_d", {26'd0, d_out}, 32'h3C);
      check("t3_hold_bw", {31'd0, bw_out}, 32'd1);
      check("t3_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    release_done("t3");
    check("t3_d_kept", {26'd0, d_out}, 32'h3C);

    out_ready = 1'b0;
    do_op("t4", 6'h30, 6'h0F, 6'h21, 1'b0, 1'b1);
    release_done("t4");

    s_in = 6'h2A;
    x_in = 6'h11;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_ready", {31'd0, in_ready}, 32'd1);
    check("t5_rst_d", {26'd0, d_out}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("t5_idle_valid", {31'd0, out_valid}, 32'd0);
    do_op("t5", 6'h3F, 6'h01, 6'h3E, 1'b0, 1'b0);
    release_done("t5");

`ifdef SUB_SIGNED_OVF_EN
    do_op("t6a", 6'h20, 6'h01, 6'h1F, 1'b0, 1'b0);
    check("t6a_sov", {31'd0, sov_out}, 32'd1);
    release_done("t6a");
    do_op("t6b", 6'h1F, 6'h3F, 6'h20, 1'b1, 1'b0);
    check("t6b_sov", {31'd0, sov_out}, 32'd1);
    release_done("t6b");
    do_op("t6c", 6'h10, 6'h01, 6'h0F, 1'b0, 1'b0);
    check("t6c_sov", {31'd0, sov_out}, 32'd0);
    release_done("t6c");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
